// File: rtl/xm23_pipe_pkg.sv
// xm23_pipe_pkg
//   Shared types for the XM23 hazard controller: forwarding selects, sequencer
//   states, scoreboard entry layout, stall-vector bit positions and the
//   scoreboard match helper.
package xm23_pipe_pkg;

    localparam int SB_NUM_REGS = 8;
    localparam int SB_REG_W    = $clog2(SB_NUM_REGS);

    localparam int STALL_LOAD = 0;
    localparam int STALL_PSW  = 1;
    localparam int STALL_SLP  = 2;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic                load;
        logic                psw_wr;
        logic [SB_REG_W-1:0] dst;
    } sb_entry_t;

    // A source depends on an in-flight entry when it really reads a GPR and
    // that entry will write the same register.
    function automatic logic sb_match(input logic use_src,
                                      input logic [SB_REG_W-1:0] src,
                                      input sb_entry_t ent);
        return use_src & ent.valid & ent.wr & (ent.dst == src);
    endfunction

endpackage

// File: rtl/xm23_scoreboard.sv
// xm23_scoreboard
//   Three-deep E/M/W shift register of scoreboard entries. A bubble (all-zero
//   entry) is inserted into E whenever nothing is pushed.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : decode instruction advances into E this cycle
//   i_entry    : entry describing the decode instruction
//   o_e/o_m/o_w: current E, M and W entries
//   o_empty    : no valid instruction in E, M or W
module xm23_scoreboard
    import xm23_pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  sb_entry_t i_entry,
    output sb_entry_t o_e,
    output sb_entry_t o_m,
    output sb_entry_t o_w,
    output logic      o_empty
);

    sb_entry_t r_e, r_m, r_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_w <= r_m;
            r_m <= r_e;
            r_e <= i_push ? i_entry : '0;
        end
    end

    assign o_e     = r_e;
    assign o_m     = r_m;
    assign o_w     = r_w;
    assign o_empty = ~(r_e.valid | r_m.valid | r_w.valid);

endmodule

// File: rtl/xm23_hazard_controller.sv
// xm23_hazard_controller
//   Stall/forwarding sequencer for the XM23 5-stage pipeline, including the
//   SLP drain/sleep/wake flow and a saturating stalled-cycle counter.
//   clk, rst_n      : clock, synchronous active-low reset
//   dec_*           : decode-stage instruction description
//   flush           : decode instruction is wrong-path
//   wake            : wake request while sleeping
//   stall_o         : stall vector (bit0 load-use, bit1 PSW, bit2 SLP)
//   fwd_a_o/fwd_b_o : operand forwarding selects
//   sleeping_o      : core is asleep
//   stall_cnt_o     : stalled cycles, saturating
//
//   state | meaning
//   RUN   | normal issue
//   DRAIN | SLP accepted, waiting for E/M/W to empty, decode held
//   SLEEP | pipeline empty, decode held until wake
module xm23_hazard_controller
    import xm23_pipe_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    parameter  int CNT_W    = 16,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_src_a,
    input  logic             dec_src_a_use,
    input  logic [REG_W-1:0] dec_src_b,
    input  logic             dec_src_b_use,
    input  logic [REG_W-1:0] dec_dst,
    input  logic             dec_wr,
    input  logic             dec_load,
    input  logic             dec_psw_rd,
    input  logic             dec_psw_wr,
    input  logic             dec_slp,
    input  logic             flush,
    input  logic             wake,
    output logic [7:0]       stall_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             sleeping_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    sb_entry_t        w_dec_entry, w_sb_e, w_sb_m, w_sb_w;
    logic             w_push, w_sb_empty;
    logic             w_load_use, w_psw_hz, w_slp_go;
    hz_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Youngest producer wins; a load still in E cannot forward yet, so the
    // search falls through to older stages (the load-use stall covers it).
    function automatic fwd_sel_e pick_fwd(input logic use_src,
                                          input logic [REG_W-1:0] src,
                                          input sb_entry_t e,
                                          input sb_entry_t m,
                                          input sb_entry_t w);
        if (sb_match(use_src, src, e) && !e.load) return FWD_EX;
        if (sb_match(use_src, src, m))            return FWD_MEM;
        if (sb_match(use_src, src, w))            return FWD_WB;
        return FWD_NONE;
    endfunction

    assign w_dec_entry = '{valid: 1'b1, wr: dec_wr, load: dec_load,
                           psw_wr: dec_psw_wr, dst: dec_dst};

    // The SLP itself is never pushed; it only starts the drain.
    assign w_push = dec_valid & ~dec_slp & ~(|stall_o) & ~flush;

    xm23_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_dec_entry),
        .o_e     (w_sb_e),
        .o_m     (w_sb_m),
        .o_w     (w_sb_w),
        .o_empty (w_sb_empty)
    );

    assign w_load_use = dec_valid & ~flush & w_sb_e.load &
                        (sb_match(dec_src_a_use, dec_src_a, w_sb_e) |
                         sb_match(dec_src_b_use, dec_src_b, w_sb_e));
    assign w_psw_hz   = dec_valid & ~flush & dec_psw_rd & w_sb_e.valid & w_sb_e.psw_wr;
    assign w_slp_go   = dec_valid & dec_slp & ~flush & ~w_load_use & ~w_psw_hz;

    always_comb begin
        stall_o            = '0;
        stall_o[STALL_LOAD] = w_load_use;
        stall_o[STALL_PSW]  = w_psw_hz;
        stall_o[STALL_SLP]  = (r_state != RUN);
    end

    assign fwd_a_o = dec_valid ? pick_fwd(dec_src_a_use, dec_src_a, w_sb_e, w_sb_m, w_sb_w)
                               : FWD_NONE;
    assign fwd_b_o = dec_valid ? pick_fwd(dec_src_b_use, dec_src_b, w_sb_e, w_sb_m, w_sb_w)
                               : FWD_NONE;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_slp_go) w_state_nxt = DRAIN;
            DRAIN:   if (flush) w_state_nxt = RUN;
                     else if (w_sb_empty) w_state_nxt = SLEEP;
            SLEEP:   if (wake) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((|stall_o) && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign sleeping_o  = (r_state == SLEEP);
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_xm23_hazard_controller.sv
module tb_xm23_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_src_a_use, dec_src_b_use;
    logic [2:0]  dec_src_a, dec_src_b, dec_dst;
    logic        dec_wr, dec_load, dec_psw_rd, dec_psw_wr, dec_slp;
    logic        flush, wake;
    logic [7:0]  stall_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        sleeping_o;
    logic [15:0] stall_cnt_o;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    xm23_hazard_controller #(.NUM_REGS(8), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (dec_valid),
        .dec_src_a     (dec_src_a),
        .dec_src_a_use (dec_src_a_use),
        .dec_src_b     (dec_src_b),
        .dec_src_b_use (dec_src_b_use),
        .dec_dst       (dec_dst),
        .dec_wr        (dec_wr),
        .dec_load      (dec_load),
        .dec_psw_rd    (dec_psw_rd),
        .dec_psw_wr    (dec_psw_wr),
        .dec_slp       (dec_slp),
        .flush         (flush),
        .wake          (wake),
        .stall_o       (stall_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .sleeping_o    (sleeping_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit wr;
        bit ld;
        bit pw;
        int dst;
    } ment_t;

    ment_t pipe[3];          // [0]=E, [1]=M, [2]=W
    int    mode;             // 0 run, 1 drain, 2 sleep
    int    m_cnt;
    int    exp_stall, exp_fa, exp_fb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hit(bit u, int s, ment_t x);
        return u && x.v && x.wr && (x.dst == s);
    endfunction

    function automatic int m_fwd(bit u, int s);
        if (!dec_valid || !u) return 0;
        for (int k = 0; k < 3; k++) begin
            if (m_hit(u, s, pipe[k])) begin
                if (k == 0 && pipe[0].ld) continue;
                return k + 1;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        mode  = 0;
        m_cnt = 0;
    endtask

    task automatic model_comb();
        exp_stall = 0;
        if (dec_valid && !flush) begin
            if (pipe[0].ld && (m_hit(dec_src_a_use, int'(dec_src_a), pipe[0]) ||
                               m_hit(dec_src_b_use, int'(dec_src_b), pipe[0])))
                exp_stall |= 1;
            if (dec_psw_rd && pipe[0].v && pipe[0].pw)
                exp_stall |= 2;
        end
        if (mode != 0) exp_stall |= 4;
        exp_fa = m_fwd(dec_src_a_use, int'(dec_src_a));
        exp_fb = m_fwd(dec_src_b_use, int'(dec_src_b));
    endtask

    task automatic model_seq();
        bit empty;
        model_comb();
        if (!rst_n) begin
            model_reset();
            return;
        end
        empty = !pipe[0].v && !pipe[1].v && !pipe[2].v;
        if (exp_stall != 0 && m_cnt < 65535) m_cnt++;
        case (mode)
            0: if (dec_valid && dec_slp && !flush && exp_stall == 0) mode = 1;
            1: if (flush) mode = 0; else if (empty) mode = 2;
            default: if (wake) mode = 0;
        endcase
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (dec_valid && !dec_slp && exp_stall == 0 && !flush)
            pipe[0] = '{v: 1'b1, wr: dec_wr, ld: dec_load, pw: dec_psw_wr, dst: int'(dec_dst)};
        else
            pipe[0] = '{default: 0};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic settle_check();
        #1;
        model_comb();
        check_eq("stall", {24'd0, stall_o}, exp_stall);
        check_eq("fwd_a", {30'd0, fwd_a_o}, exp_fa);
        check_eq("fwd_b", {30'd0, fwd_b_o}, exp_fb);
        check_eq("sleep", {31'd0, sleeping_o}, (mode == 2) ? 1 : 0);
        check_eq("cnt",   {16'd0, stall_cnt_o}, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic clear_in();
        dec_valid = 0; dec_src_a = 0; dec_src_a_use = 0; dec_src_b = 0; dec_src_b_use = 0;
        dec_dst = 0; dec_wr = 0; dec_load = 0; dec_psw_rd = 0; dec_psw_wr = 0;
        dec_slp = 0; flush = 0; wake = 0;
    endtask

    task automatic set_ins(input bit wr, input int dst, input bit ua, input int a,
                           input bit ub, input int b, input bit ld, input bit pr, input bit pw);
        clear_in();
        dec_valid = 1; dec_wr = wr; dec_dst = 3'(dst);
        dec_src_a_use = ua; dec_src_a = 3'(a);
        dec_src_b_use = ub; dec_src_b = 3'(b);
        dec_load = ld; dec_psw_rd = pr; dec_psw_wr = pw;
    endtask

    task automatic set_slp();
        clear_in();
        dec_valid = 1; dec_slp = 1;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        advance();
        advance();
        rst_n = 1;
        settle_check();
    endtask

    task automatic wait_sleep(input string tag);
        for (int i = 0; i < 12; i++) begin
            settle_check();
            if (sleeping_o) break;
            advance();
        end
        check_eq(tag, {31'd0, sleeping_o}, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_in();
        rst_n = 0;
        do_reset();
        check_eq("rst_stall", {24'd0, stall_o}, 0);
        check_eq("rst_cnt", {16'd0, stall_cnt_o}, 0);
        check_eq("rst_sleep", {31'd0, sleeping_o}, 0);

        // 1: back-to-back ALU dependency
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        set_ins(1, 2, 0, 0, 1, 1, 0, 0, 0); settle_check();
        check_eq("t1_fwd_ex", {30'd0, fwd_b_o}, 1);
        check_eq("t1_nostall", {24'd0, stall_o}, 0);
        advance();
        set_ins(1, 3, 0, 0, 1, 1, 0, 0, 0); settle_check();
        check_eq("t1_fwd_mem", {30'd0, fwd_b_o}, 2);
        advance();

        // 2: load-use
        do_reset();
        set_ins(1, 3, 0, 0, 0, 0, 1, 0, 0); settle_check(); advance();
        set_ins(1, 4, 1, 3, 0, 0, 0, 0, 0); settle_check();
        check_eq("t2_stall", {24'd0, stall_o}, 8'h01);
        advance();
        settle_check();
        check_eq("t2_release", {24'd0, stall_o}, 0);
        check_eq("t2_fwd_mem", {30'd0, fwd_a_o}, 2);
        check_eq("t2_cnt", {16'd0, stall_cnt_o}, 1);
        advance();

        // 3: PSW hazard, then youngest-wins forwarding
        do_reset();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 1); settle_check(); advance();
        set_ins(1, 6, 0, 0, 0, 0, 0, 1, 0); settle_check();
        check_eq("t3_psw", {24'd0, stall_o}, 8'h02);
        advance();
        settle_check();
        check_eq("t3_release", {24'd0, stall_o}, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            set_ins(1, 5, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        end
        set_ins(1, 7, 1, 5, 1, 5, 0, 0, 0); settle_check();
        check_eq("t3_youngest", {30'd0, fwd_a_o}, 1);
        advance();

        // 4: SLP drain / sleep / wake
        do_reset();
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        set_ins(1, 2, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        set_slp(); settle_check(); advance();
        set_ins(1, 3, 1, 2, 0, 0, 0, 0, 0); settle_check();
        check_eq("t4_drain", {24'd0, stall_o}, 8'h04);
        wait_sleep("t4_sleep");
        for (int i = 0; i < 3; i++) begin
            advance(); settle_check();
        end
        wake = 1; settle_check(); advance();
        wake = 0; settle_check();
        check_eq("t4_wake_stall", {24'd0, stall_o}, 0);
        check_eq("t4_wake_sleep", {31'd0, sleeping_o}, 0);
        advance();

        // 5: flush interactions with SLP
        do_reset();
        set_slp(); flush = 1; settle_check(); advance();
        clear_in(); settle_check();
        check_eq("t5_no_drain", {24'd0, stall_o}, 0);
        advance();
        set_ins(1, 6, 0, 0, 0, 0, 0, 0, 0); flush = 1; settle_check(); advance();
        set_ins(1, 7, 1, 6, 0, 0, 0, 0, 0); settle_check();
        check_eq("t5_bubble", {30'd0, fwd_a_o}, 0);
        advance();
        set_ins(1, 1, 0, 0, 0, 0, 0, 0, 0); settle_check(); advance();
        set_slp(); settle_check(); advance();
        clear_in(); settle_check();
        check_eq("t5_in_drain", {24'd0, stall_o}, 8'h04);
        flush = 1; settle_check(); advance();
        flush = 0; settle_check();
        check_eq("t5_flush_drain", {24'd0, stall_o}, 0);
        advance(); settle_check();
        check_eq("t5_still_run", {31'd0, sleeping_o}, 0);

        // 6: long sleep saturates the counter, reset from SLEEP
        do_reset();
        set_slp(); settle_check(); advance();
        clear_in();
        wait_sleep("t6_sleep");
        for (int i = 0; i < 65541; i++) advance();
        settle_check();
        check_eq("t6_sat", {16'd0, stall_cnt_o}, 16'hFFFF);
        rst_n = 0; advance(); settle_check();
        check_eq("t6_rst_cnt", {16'd0, stall_cnt_o}, 0);
        check_eq("t6_rst_sleep", {31'd0, sleeping_o}, 0);
        check_eq("t6_rst_stall", {24'd0, stall_o}, 0);
        rst_n = 1;

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            dec_valid     = ($urandom_range(0, 3) != 0);
            dec_src_a     = 3'($urandom_range(0, 7));
            dec_src_b     = 3'($urandom_range(0, 7));
            dec_dst       = 3'($urandom_range(0, 7));
            dec_src_a_use = 1'($urandom_range(0, 1));
            dec_src_b_use = 1'($urandom_range(0, 1));
            dec_wr        = ($urandom_range(0, 3) != 0);
            dec_load      = ($urandom_range(0, 3) == 0);
            dec_psw_rd    = ($urandom_range(0, 3) == 0);
            dec_psw_wr    = ($urandom_range(0, 2) == 0);
            dec_slp       = ($urandom_range(0, 15) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            wake          = ($urandom_range(0, 3) == 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            settle_check();
            advance();
        end
        rst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
